// File: rtl/sprite_engine_if.sv
// CPU register bus of the sprite engine: the address decoder and CPU drive the master side.
interface sprite_engine_if #(
  parameter int unsigned A = 7
);
  logic [A-1:0] addr;
  logic         cs;
  logic         rw;
  logic [7:0]   di;
  logic [7:0]   dout;

  modport master (output addr, output cs, output rw, output di, input dout);
  modport slave  (input addr, input cs, input rw, input di, output dout);
endinterface

// File: rtl/sprite_engine.sv
// Multi-sprite generator: CPU register file, per-scanline row fetch during hsync,
// fixed-priority pixel render and sticky collision detection.
module sprite_engine #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  parameter int unsigned H = 8,
  parameter int unsigned A = 7
) (
  input  logic           clk,
  input  logic           reset,
  sprite_engine_if.slave bus,
  input  logic [7:0]     hpos,
  input  logic [6:0]     vpos,
  input  logic           hsync,
  input  logic           vsync,
  output logic [3:0]     color,
  output logic           pixel
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = A - 4;
  localparam logic [A-1:0] COLL_ADDR = A'(N * 16);
  localparam logic [A-1:0] STAT_ADDR = A'(N * 16 + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DONE} state_e;

  logic [7:0]   x_q   [N];
  logic [6:0]   y_q   [N];
  logic         en_q  [N];
  logic [3:0]   pal_q [N];
  logic [7:0]   bmp_q [N][H];
  logic [N-1:0] coll_q, coll_d;

  logic [7:0]   sh_q   [N];
  logic [7:0]   sx_q   [N];
  logic [3:0]   scol_q [N];
  logic [N-1:0] act_q;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          hsync_q;
  logic          fetch_c, last_c;

  logic [SW-1:0] slot_c;
  logic [3:0]    off_c;
  logic          in_slots_c, wr_c, rd_c, coll_rd_c;
  logic [7:0]    rdata_c;

  logic [6:0]   row_c;
  logic         hit_c;
  logic [7:0]   rowbits_c, fx_c;
  logic [3:0]   fpal_c;
  logic [N-1:0] opq_c;
  logic         multi_c;
  logic [3:0]   color_d;
  logic         pixel_d;

  assign slot_c     = bus.addr[A-1:4];
  assign off_c      = bus.addr[3:0];
  assign in_slots_c = bus.addr < COLL_ADDR;
  assign wr_c       = bus.cs & bus.rw;
  assign rd_c       = bus.cs & ~bus.rw;
  assign coll_rd_c  = rd_c & (bus.addr == COLL_ADDR);

  // CPU read mux
  always_comb begin
    rdata_c = 8'h00;
    if (in_slots_c) begin
      for (int s = 0; s < N; s++) begin
        if (slot_c == SW'(s)) begin
          case (off_c)
            4'd0:    rdata_c = x_q[s];
            4'd1:    rdata_c = {1'b0, y_q[s]};
            4'd2:    rdata_c = {en_q[s], 3'b000, pal_q[s]};
            default: begin
              for (int r = 0; r < H; r++)
                if (off_c == 4'(4 + r)) rdata_c = bmp_q[s][r];
            end
          endcase
        end
      end
    end else if (bus.addr == COLL_ADDR) begin
      rdata_c = 8'(coll_q);
    end else if (bus.addr == STAT_ADDR) begin
      rdata_c = {6'b000000, fetch_c, vsync};
    end
  end

  assign bus.dout = rd_c ? rdata_c : 8'h00;

  // CPU register writes; unused attribute bits are not stored
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < N; s++) begin
        x_q[s]   <= '0;
        y_q[s]   <= '0;
        en_q[s]  <= 1'b0;
        pal_q[s] <= '0;
        for (int r = 0; r < H; r++) bmp_q[s][r] <= '0;
      end
    end else if (wr_c && in_slots_c) begin
      for (int s = 0; s < N; s++) begin
        if (slot_c == SW'(s)) begin
          case (off_c)
            4'd0: x_q[s] <= bus.di;
            4'd1: y_q[s] <= bus.di[6:0];
            4'd2: begin
              en_q[s]  <= bus.di[7];
              pal_q[s] <= bus.di[3:0];
            end
            default: begin
              for (int r = 0; r < H; r++)
                if (off_c == 4'(4 + r)) bmp_q[s][r] <= bus.di;
            end
          endcase
        end
      end
    end
  end

  // Fetch FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hsync_q <= hsync;
    end
  end

  // Fetch FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (vsync) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (hsync && !hsync_q) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
        ST_FETCH: if (last_c) state_d = ST_DONE;
                  else        idx_d   = idx_q + IW'(1);
        ST_DONE:  if (!hsync) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Fetch FSM: outputs
  always_comb begin
    fetch_c = (state_q == ST_FETCH);
    last_c  = (idx_q == IW'(N - 1));
  end

  // Row selection for the sprite being fetched this cycle
  always_comb begin
    row_c     = '0;
    hit_c     = 1'b0;
    rowbits_c = '0;
    fx_c      = '0;
    fpal_c    = '0;
    for (int s = 0; s < N; s++) begin
      if (idx_q == IW'(s)) begin
        row_c  = vpos - y_q[s];
        hit_c  = en_q[s] && (row_c < 7'(H));
        fx_c   = x_q[s];
        fpal_c = pal_q[s];
        for (int r = 0; r < H; r++)
          if (row_c == 7'(r)) rowbits_c = bmp_q[s][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < N; s++) begin
        sh_q[s]   <= '0;
        sx_q[s]   <= '0;
        scol_q[s] <= '0;
      end
      act_q <= '0;
    end else if (vsync) begin
      act_q <= '0;
    end else if (fetch_c) begin
      for (int s = 0; s < N; s++) begin
        if (idx_q == IW'(s)) begin
          act_q[s] <= hit_c;
          if (hit_c) begin
            sh_q[s]   <= rowbits_c;
            sx_q[s]   <= fx_c;
            scol_q[s] <= fpal_c;
          end
        end
      end
    end
  end

  // Render: walk from highest index down so the lowest opaque index wins
  always_comb begin
    logic [7:0] col;
    col     = '0;
    opq_c   = '0;
    color_d = 4'h0;
    for (int s = int'(N) - 1; s >= 0; s--) begin
      col      = hpos - sx_q[s];
      opq_c[s] = act_q[s] && (col < 8'(W)) && sh_q[s][3'(7) - col[2:0]];
      if (opq_c[s]) color_d = scol_q[s];
    end
    pixel_d = |opq_c;
  end

  // A COLL read clears old bits but never drops a collision seen in the same cycle
  assign multi_c = |(opq_c & (opq_c - N'(1)));
  always_comb begin
    coll_d = (coll_rd_c ? '0 : coll_q) |
             ((multi_c && !hsync && !vsync) ? opq_c : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      color  <= 4'h0;
      pixel  <= 1'b0;
      coll_q <= '0;
    end else begin
      color  <= color_d;
      pixel  <= pixel_d;
      coll_q <= coll_d;
    end
  end
endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: directed vector table plus randomized
// sprite scenes compared against a painter's-algorithm scanline model.
module tb_sprite_engine;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned H = 8;
  localparam int unsigned A = 7;
  localparam int COLL = N * 16;
  localparam int STAT = N * 16 + 1;

  typedef struct {
    logic [7:0] h;
    logic [3:0] c;
    logic       p;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hpos;
  logic [6:0] vpos;
  logic       hsync, vsync;
  logic [3:0] color;
  logic       pixel;

  sprite_engine_if #(.A(A)) bus ();

  sprite_engine #(.N(N), .W(W), .H(H), .A(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .hpos  (hpos),
    .vpos  (vpos),
    .hsync (hsync),
    .vsync (vsync),
    .color (color),
    .pixel (pixel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: register image, one painted scanline, sticky collisions
  logic [7:0]   mregs [2**A];
  logic [3:0]   fb    [256];
  logic [N-1:0] cov   [256];
  logic [N-1:0] mcoll;
  vec_t         vt    [38];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int h, input int c, input int p);
    vec_t v;
    v.h = 8'(h);
    v.c = 4'(c);
    v.p = 1'(p);
    return v;
  endfunction

  function automatic logic [7:0] wmask(input int a);
    int off;
    off = a % 16;
    if (a >= N * 16) return 8'h00;
    if (off == 0) return 8'hFF;
    if (off == 1) return 8'h7F;
    if (off == 2) return 8'h8F;
    if (off >= 4 && off < 4 + H) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    if (a == COLL) return 8'(mcoll);
    return mregs[a];
  endfunction

  task automatic model_blank();
    for (int h = 0; h < 256; h++) begin
      fb[h]  = 4'h0;
      cov[h] = '0;
    end
  endtask

  // Paint every sprite row that lands on scanline v, highest index first
  task automatic model_fetch(input logic [6:0] v);
    model_blank();
    for (int s = int'(N) - 1; s >= 0; s--) begin
      int x, y, row, hh;
      logic [7:0] at, bits;
      x   = int'(mregs[s*16]);
      y   = int'(mregs[s*16+1]);
      at  = mregs[s*16+2];
      row = (int'(v) - y + 128) % 128;
      if (at[7] && row < int'(H)) begin
        bits = mregs[s*16+4+row];
        for (int c = 0; c < 8; c++) begin
          if (bits[7-c]) begin
            hh = (x + c) % 256;
            fb[hh] = at[3:0];
            cov[hh][s] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic clock_edge();
    logic [N-1:0] hit, newb;
    logic rd, rs, hs, vs;
    rd  = bus.cs && !bus.rw && (bus.addr == A'(COLL));
    hit = cov[hpos];
    rs  = reset;
    hs  = hsync;
    vs  = vsync;
    @(posedge clk);
    if (rs) begin
      for (int a = 0; a < 2**A; a++) mregs[a] = 8'h00;
      model_blank();
      mcoll = '0;
    end else begin
      newb  = (!hs && !vs && $countones(hit) >= 2) ? hit : '0;
      mcoll = (rd ? '0 : mcoll) | newb;
      if (vs) model_blank();
    end
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.addr = A'(a);
    bus.cs   = 1'b1;
    bus.rw   = 1'b1;
    bus.di   = d;
    clock_edge();
    bus.cs = 1'b0;
    bus.rw = 1'b0;
    if (a < N * 16) mregs[a] = d & wmask(a);
  endtask

  task automatic rd(input string name, input int a, output logic [7:0] got);
    bus.addr = A'(a);
    bus.cs   = 1'b1;
    bus.rw   = 1'b0;
    #1;
    got = bus.dout;
    check(name, got, model_read(a));
    clock_edge();
    bus.cs = 1'b0;
  endtask

  task automatic tick(input logic [7:0] h, input logic rd_coll,
                      output logic [3:0] c, output logic p, output logic [7:0] d);
    d    = 8'h00;
    hpos = h;
    if (rd_coll) begin
      bus.addr = A'(COLL);
      bus.cs   = 1'b1;
      bus.rw   = 1'b0;
      #1;
      d = bus.dout;
      check($sformatf("coll_rd@%0d", h), d, 8'(mcoll));
    end
    clock_edge();
    bus.cs = 1'b0;
    c = color;
    p = pixel;
    check($sformatf("color@%0d", h), c, fb[h]);
    check($sformatf("pixel@%0d", h), p, cov[h] != '0);
  endtask

  task automatic fetch_line(input logic [6:0] v);
    vpos  = v;
    hsync = 1'b1;
    model_fetch(v);
    clock_edge();
    bus.addr = A'(STAT);
    bus.cs   = 1'b1;
    bus.rw   = 1'b0;
    #1;
    check("status_busy", bus.dout, 8'h02);
    clock_edge();
    bus.cs = 1'b0;
    repeat (N + 1) clock_edge();
    hsync = 1'b0;
    clock_edge();
  endtask

  task automatic run_tbl(input int lo, input int hi);
    logic [3:0] c;
    logic       p;
    logic [7:0] d;
    for (int i = lo; i <= hi; i++) begin
      tick(vt[i].h, 1'b0, c, p, d);
      check($sformatf("tbl%0d_color", i), c, vt[i].c);
      check($sformatf("tbl%0d_pixel", i), p, vt[i].p);
    end
  endtask

  initial begin
    logic [7:0] got;
    logic [3:0] c;
    logic       p;

    vt[0] = mk(9, 0, 0);    vt[1] = mk(10, 3, 1);   vt[2] = mk(11, 0, 0);
    vt[3] = mk(12, 0, 0);   vt[4] = mk(13, 0, 0);   vt[5] = mk(14, 0, 0);
    vt[6] = mk(15, 0, 0);   vt[7] = mk(16, 0, 0);   vt[8] = mk(17, 3, 1);
    vt[9] = mk(18, 0, 0);
    vt[10] = mk(13, 3, 1);  vt[11] = mk(19, 0, 0);  vt[12] = mk(20, 3, 1);
    vt[13] = mk(21, 0, 0);
    vt[14] = mk(251, 0, 0); vt[15] = mk(252, 3, 1); vt[16] = mk(253, 0, 0);
    vt[17] = mk(254, 3, 1); vt[18] = mk(255, 0, 0); vt[19] = mk(0, 0, 0);
    vt[20] = mk(1, 3, 1);   vt[21] = mk(2, 0, 0);   vt[22] = mk(3, 3, 1);
    vt[23] = mk(4, 0, 0);
    vt[24] = mk(252, 3, 1); vt[25] = mk(100, 0, 0);
    vt[26] = mk(100, 3, 1); vt[27] = mk(252, 0, 0); vt[28] = mk(102, 3, 1);
    vt[29] = mk(101, 0, 0);
    vt[30] = mk(100, 9, 1); vt[31] = mk(102, 9, 1); vt[32] = mk(107, 9, 1);
    vt[33] = mk(108, 0, 0);
    vt[34] = mk(100, 3, 1); vt[35] = mk(101, 9, 1); vt[36] = mk(200, 0, 0);
    vt[37] = mk(100, 0, 0);

    for (int a = 0; a < 2**A; a++) mregs[a] = 8'h00;
    model_blank();
    mcoll    = '0;
    reset    = 1'b1;
    hpos     = 8'd0;
    vpos     = 7'd0;
    hsync    = 1'b0;
    vsync    = 1'b0;
    bus.addr = '0;
    bus.cs   = 1'b0;
    bus.rw   = 1'b0;
    bus.di   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_color", color, 4'h0);
    check("rst_pixel", pixel, 1'b0);
    reset = 1'b0;
    clock_edge();
    for (int a = 0; a < 2**A; a++) begin
      rd($sformatf("rst_rd%0d", a), a, got);
      check($sformatf("rst_zero%0d", a), got, 8'h00);
    end

    // Single sprite, 1-cycle render latency
    wr(0, 8'd10); wr(1, 8'd5); wr(2, 8'h83); wr(4, 8'h81);
    rd("x_readback", 0, got);
    check("x_value", got, 8'd10);
    fetch_line(7'd5);
    run_tbl(0, 9);

    // Overlap: priority and collision read-clear
    wr(0, 8'd13); wr(16, 8'd20); wr(17, 8'd5); wr(18, 8'h89); wr(20, 8'h80);
    fetch_line(7'd5);
    run_tbl(10, 13);
    rd("coll_first", COLL, got);  check("coll_first_val", got, 8'h03);
    rd("coll_second", COLL, got); check("coll_second_val", got, 8'h00);

    // Vertical and horizontal wrap
    wr(0, 8'd252); wr(1, 8'd126); wr(8, 8'hA5); wr(18, 8'h09);
    fetch_line(7'd2);
    run_tbl(14, 23);

    // Mid-line X write waits for the next fetch
    wr(0, 8'd100);
    run_tbl(24, 25);
    fetch_line(7'd2);
    run_tbl(26, 29);

    // Disabled sprite is invisible and cannot collide
    wr(2, 8'h03); wr(16, 8'd100); wr(17, 8'd2); wr(18, 8'h89); wr(20, 8'hFF);
    fetch_line(7'd2);
    run_tbl(30, 33);
    rd("coll_disabled", COLL, got); check("coll_disabled_val", got, 8'h00);

    // Collision coinciding with a COLL read
    wr(2, 8'h83);
    fetch_line(7'd2);
    run_tbl(34, 36);
    wr(18, 8'h09); wr(32, 8'd100); wr(33, 8'd2); wr(34, 8'h85); wr(36, 8'hFF);
    fetch_line(7'd2);
    tick(8'd100, 1'b1, c, p, got);
    check("coll_same_old", got, 8'h03);
    check("coll_same_color", c, 4'h3);
    tick(8'd200, 1'b0, c, p, got);
    rd("coll_after", COLL, got);  check("coll_after_val", got, 8'h05);
    rd("coll_cleared", COLL, got); check("coll_cleared_val", got, 8'h00);

    // vsync drops the latched line
    vsync    = 1'b1;
    bus.addr = A'(STAT);
    bus.cs   = 1'b1;
    bus.rw   = 1'b0;
    #1;
    check("status_vsync", bus.dout, 8'h01);
    clock_edge();
    bus.cs = 1'b0;
    vsync  = 1'b0;
    run_tbl(37, 37);

    // Random scenes against the scanline model
    for (int ln = 0; ln < 6; ln++) begin
      logic [6:0] v;
      v = 7'($urandom_range(0, 127));
      for (int s = 0; s < N; s++) begin
        wr(s * 16, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 60)));
        wr(s * 16 + 1, 8'(v - 7'($urandom_range(0, H + 1))));
        wr(s * 16 + 2, 8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h80 : 8'h00));
        wr(s * 16 + 3, 8'($urandom));
        for (int r = 0; r < H; r++) wr(s * 16 + 4 + r, 8'($urandom));
      end
      wr(COLL, 8'($urandom));
      wr(STAT, 8'($urandom));
      fetch_line(v);
      for (int h = 0; h < 256; h++) tick(8'(h), $urandom_range(0, 15) == 0, c, p, got);
      for (int k = 0; k < 8; k++) rd("rand_rd", int'($urandom_range(0, 2**A - 1)), got);
    end

    // Reset in the middle of a fetch leaves the line blank
    hsync = 1'b1;
    model_fetch(vpos);
    clock_edge();
    clock_edge();
    reset = 1'b1;
    clock_edge();
    reset = 1'b0;
    repeat (N + 2) clock_edge();
    hsync = 1'b0;
    clock_edge();
    for (int h = 0; h < 16; h++) tick(8'(h * 16 + 5), 1'b0, c, p, got);
    rd("post_rst_x0", 0, got);   check("post_rst_x0_val", got, 8'h00);
    rd("post_rst_coll", COLL, got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_engine.md
# sprite_engine

Multi-sprite video generator, parametrised in sprite count, width and height. Replaces the single-sprite unit on the CPU bus. Each sprite has per-sprite position, colour, enable and bitmap registers, plus fixed index priority and sticky hardware collision detection. A per-scanline fetch FSM runs during hsync and latches each sprite's row into a shifter. The engine outputs a 4-bit palette index to the palette stage.

## Interface
Parameters:
- N, 4: number of sprites, 1..8.
- W, 8: sprite width in pixels. Fixed at 8, so one bitmap byte holds one row.
- H, 8: sprite height in rows, 1..8.
- A, 7: address width, must satisfy 2^A ≥ N*16+2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- addr  in  A  register address
- cs  in  1  chip select from address decoder
- rw  in  1  1 = CPU write, 0 = CPU read
- di  in  8  CPU write data
- dout  out  8  CPU read data
- hpos  in  8  current pixel column
- vpos  in  7  current scanline
- hsync  in  1  horizontal sync, active high
- vsync  in  1  vertical sync, active high
- color  out  4  palette index, 0 = transparent
- pixel  out  1  1 when any sprite is opaque at this pixel

Clock and reset: one clock domain, `clk`. Reset is synchronous and active-high on `reset`.

## Operation
Register map (slot s = 0..N-1 at base s*16):
- +0 X (8b)
- +1 Y (7b, bit 7 reads 0)
- +2 ATTR: bit7 = enable, bits3:0 = colour, other bits read 0
- +3 reserved, reads 0
- +4..+4+H-1 bitmap rows. Row 0 is the top row; bit 7 is the leftmost pixel.

Global registers:
- N*16+0 COLL: bit s set when sprite s has collided. Sticky; a CPU read clears it.
- N*16+1 STATUS: bit0 = vsync, bit1 = fetch busy.

Unmapped reads return 0x00. Writes to unmapped or read-only addresses are ignored.

Bus behaviour:
- Write occurs on the clk edge when cs & rw.
- dout is combinational, equal to the addressed register when cs & ~rw, else 0x00.

Fetch FSM (states IDLE, FETCH, DONE):
- IDLE → FETCH on the rising edge of hsync.
- FETCH visits s = 0..N-1, one sprite per cycle.
- For each sprite, row = (vpos − Y) mod 128. The sprite hits if enable=1 and row < H.
- On a hit: load shifter[s] ← bitmap[row], latch x[s] ← X, colour[s] ← colour, active[s] ← 1. Otherwise active[s] ← 0.
- After s = N-1 → DONE. DONE → IDLE when hsync falls.
- vsync high forces IDLE and clears all active[s].
- Register writes made mid-line take effect at the next fetch.

Render, per cycle:
- col = (hpos − x[s]) mod 256.
- Sprite s is opaque when active[s] & col < 8 & shifter[s] bit (7−col). Bit is indexed directly; no destructive shifting.
- Horizontal wrap and vertical wrap (Y near 127) are natural consequences of the modular arithmetic.
- color = colour of the lowest-index opaque sprite; 0 if no sprite is opaque. pixel = any opaque.
- Collision: if ≥2 sprites are opaque in the same cycle, set the COLL bit for every opaque sprite.
- Collision setting is disabled while hsync or vsync is high.
- A COLL read in the same cycle as a new collision: all bits clear, then the newly colliding bits are set, so the new bits survive.

Reset: all registers, shifters and active flags are 0, COLL = 0, color = 0, pixel = 0, FSM in IDLE.

## Timing
- color and pixel are registered: the value for hpos=h appears on the cycle after hpos=h is presented.
- Fetch takes N cycles starting the cycle after the hsync rise. hsync must stay high for ≥ N+1 cycles.
- A register write is visible on dout the next cycle.
- Reset asserted mid-fetch: FSM returns to IDLE, and the line renders blank until the next complete fetch.

## Test plan
- Reset → color=0, pixel=0, COLL=0. dout=0x00 for all addresses.
- Sprite 0: X=10, Y=5, ATTR=0x83, row0=0x81; vpos=5 fetch → color=3 for hpos 10 and 17, 0 for hpos 11..16, with 1-cycle latency.
- Sprites 0 (colour 3) and 1 (colour 9) overlap at hpos=20 → color=3 there. COLL reads 0x03, then reads 0x00 on the following read.
- Sprite at Y=126, H=8; vpos=2 → row 4 displayed. Sprite at X=252 → pixels 4..7 of the row appear at hpos 0..3.
- Write X mid-line (hsync low) → current line unchanged, new position appears on the next line. ATTR enable=0 → no pixels and no collision.
- Collision in the same cycle as a COLL read → read returns old bits, and the new collision bits remain set afterwards.
